// File: rtl/cordic_fixed_pkg.sv
// Fixed-point 1.2.13 phase constants and types shared by the phase generator
// and its wrap adder.
package cordic_fixed_pkg;

  localparam int PHASE_W = 16;

  typedef logic signed [PHASE_W-1:0] phase_t;

  localparam phase_t PI_POS = 16'sh6488;
  localparam phase_t PI_NEG = 16'sh9B78;
  localparam logic signed [PHASE_W:0] TWO_PI = 17'sd51472;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } gen_state_e;

  // Increments outside [-pi, +pi] could step a phase past a single wrap.
  function automatic logic inc_in_range(input phase_t inc);
    return (inc >= PI_NEG) && (inc <= PI_POS);
  endfunction

endpackage

// File: rtl/phase_wrap_add.sv
// Combinational phase accumulate step: phase + inc, folded back into [-pi, +pi].
// The sum is formed at PHASE_W+1 bits so the out-of-range value is never aliased.
module phase_wrap_add
  import cordic_fixed_pkg::*;
(
  input  phase_t phase_i,
  input  phase_t inc_i,
  output phase_t phase_o
);

  logic signed [PHASE_W:0] sum;
  logic signed [PHASE_W:0] wrapped;

  always_comb begin
    sum     = {phase_i[PHASE_W-1], phase_i} + {inc_i[PHASE_W-1], inc_i};
    wrapped = sum;
    // Exactly +pi or -pi is a legal phase and stays as is.
    if (sum > PI_POS) begin
      wrapped = sum - TWO_PI;
    end else if (sum < PI_NEG) begin
      wrapped = sum + TWO_PI;
    end
    phase_o = wrapped[PHASE_W-1:0];
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// Dual-tone phase ramp source for the CORDIC pair, presented as an AXI-Stream
// master with fixed-length frames and runtime-loadable increments.
module cordic_phase_gen
  import cordic_fixed_pkg::*;
#(
  parameter int     FRAME_LEN = 256,
  parameter phase_t INC_A_RST = 16'sd200,
  parameter phase_t INC_B_RST = 16'sd3000
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic                      CLEAR,
  input  logic                      INC_LOAD,
  input  logic signed [PHASE_W-1:0] INC_A,
  input  logic signed [PHASE_W-1:0] INC_B,
  output logic                      M_AXIS_PHASE_TVALID,
  input  logic                      M_AXIS_PHASE_TREADY,
  output logic [2*PHASE_W-1:0]      M_AXIS_PHASE_TDATA,
  output logic                      M_AXIS_PHASE_TLAST,
  output logic                      INC_ERR
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  gen_state_e  state_q, state_d;
  phase_t      phase_a_q, phase_a_d, phase_b_q, phase_b_d;
  phase_t      inc_a_q, inc_a_d, inc_b_q, inc_b_d;
  phase_t      phase_a_sum, phase_b_sum;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        inc_err_q, inc_err_d;
  logic        handshake;
  logic        load_ok;

  phase_wrap_add u_wrap_a (
    .phase_i (phase_a_q),
    .inc_i   (inc_a_q),
    .phase_o (phase_a_sum)
  );

  phase_wrap_add u_wrap_b (
    .phase_i (phase_b_q),
    .inc_i   (inc_b_q),
    .phase_o (phase_b_sum)
  );

  // TVALID is exactly "in RUN", so a beat can only leave via a handshake.
  assign handshake = (state_q == ST_RUN) && M_AXIS_PHASE_TREADY;
  assign load_ok   = inc_in_range(INC_A) && inc_in_range(INC_B);

  always_comb begin
    state_d     = state_q;
    phase_a_d   = phase_a_q;
    phase_b_d   = phase_b_q;
    inc_a_d     = inc_a_q;
    inc_b_d     = inc_b_q;
    frame_cnt_d = frame_cnt_q;
    inc_err_d   = inc_err_q;

    case (state_q)
      ST_IDLE: begin
        if (CLEAR) begin
          phase_a_d   = '0;
          phase_b_d   = '0;
          frame_cnt_d = '0;
        end
        if (EN) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (handshake) begin
          phase_a_d   = phase_a_sum;
          phase_b_d   = phase_b_sum;
          frame_cnt_d = (frame_cnt_q == LAST_IDX) ? '0 : frame_cnt_q + 16'd1;
          if (!EN) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The update above uses the old increments; a load takes effect from the next one.
    if (INC_LOAD) begin
      if (load_ok) begin
        inc_a_d = INC_A;
        inc_b_d = INC_B;
      end else begin
        inc_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      phase_a_q   <= '0;
      phase_b_q   <= '0;
      inc_a_q     <= INC_A_RST;
      inc_b_q     <= INC_B_RST;
      frame_cnt_q <= '0;
      inc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_a_q   <= phase_a_d;
      phase_b_q   <= phase_b_d;
      inc_a_q     <= inc_a_d;
      inc_b_q     <= inc_b_d;
      frame_cnt_q <= frame_cnt_d;
      inc_err_q   <= inc_err_d;
    end
  end

  assign M_AXIS_PHASE_TVALID = (state_q == ST_RUN);
  assign M_AXIS_PHASE_TDATA  = {phase_b_q, phase_a_q};
  assign M_AXIS_PHASE_TLAST  = (state_q == ST_RUN) && (frame_cnt_q == LAST_IDX);
  assign INC_ERR             = inc_err_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Randomized and directed bench for cordic_phase_gen against an integer
// reference model of the phase ramps, wrap rule, frame index and load checks.
module tb_cordic_phase_gen;

  localparam int FL     = 4;
  localparam int PI_P   = 25736;
  localparam int TWO_PI = 51472;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               clear;
  logic               inc_load;
  logic signed [15:0] inc_a;
  logic signed [15:0] inc_b;
  logic               tvalid;
  logic               tready;
  logic [31:0]        tdata;
  logic               tlast;
  logic               inc_err;

  int checks = 0;
  int errors = 0;

  int m_pa, m_pb, m_inca, m_incb, m_cnt;
  bit m_valid, m_err;
  int beat_no = 0;
  logic [31:0] obs_q[$];

  always #5 clk = ~clk;

  cordic_phase_gen #(
    .FRAME_LEN (FL),
    .INC_A_RST (16'sd200),
    .INC_B_RST (16'sd3000)
  ) dut (
    .CLK                 (clk),
    .RST_N               (rst_n),
    .EN                  (en),
    .CLEAR               (clear),
    .INC_LOAD            (inc_load),
    .INC_A               (inc_a),
    .INC_B               (inc_b),
    .M_AXIS_PHASE_TVALID (tvalid),
    .M_AXIS_PHASE_TREADY (tready),
    .M_AXIS_PHASE_TDATA  (tdata),
    .M_AXIS_PHASE_TLAST  (tlast),
    .INC_ERR             (inc_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int s);
    if (s > PI_P) return s - TWO_PI;
    if (s < -PI_P) return s + TWO_PI;
    return s;
  endfunction

  function automatic bit in_rng(input int v);
    return (v >= -PI_P) && (v <= PI_P);
  endfunction

  task automatic model_reset();
    m_pa = 0; m_pb = 0; m_inca = 200; m_incb = 3000;
    m_cnt = 0; m_valid = 0; m_err = 0;
  endtask

  task automatic compare_outputs();
    check("tvalid", {31'd0, tvalid}, {31'd0, m_valid});
    check("inc_err", {31'd0, inc_err}, {31'd0, m_err});
    if (m_valid) begin
      check("phase_a", {16'd0, tdata[15:0]}, {16'd0, 16'(m_pa)});
      check("phase_b", {16'd0, tdata[31:16]}, {16'd0, 16'(m_pb)});
      check("tlast", {31'd0, tlast}, {31'd0, (m_cnt == FL - 1)});
    end
  endtask

  // Advance model and DUT by one clock using the inputs currently driven.
  task automatic cycle();
    bit hs;
    if (tvalid && tready && rst_n) begin
      obs_q.push_back(tdata);
      $display("beat %0d A=%0d B=%0d last=%0b", beat_no, $signed(tdata[15:0]),
               $signed(tdata[31:16]), tlast);
      beat_no++;
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      hs = m_valid && tready;
      if (hs) begin
        m_pa  = wrap(m_pa + m_inca);
        m_pb  = wrap(m_pb + m_incb);
        m_cnt = (m_cnt + 1) % FL;
      end
      if (!m_valid && clear) begin
        m_pa = 0; m_pb = 0; m_cnt = 0;
      end
      if (inc_load) begin
        if (in_rng(int'(inc_a)) && in_rng(int'(inc_b))) begin
          m_inca = int'(inc_a);
          m_incb = int'(inc_b);
        end else begin
          m_err = 1;
        end
      end
      m_valid = en || (m_valid && !hs);
    end
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
    clear    = 1'b0;
    inc_load = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; inc_load = 1'b0;
    inc_a = '0; inc_b = '0; tready = 1'b0;
    model_reset();

    // Reset defaults
    cycle();
    cycle();
    check("rst_tdata", tdata, 32'd0);
    check("rst_tlast", {31'd0, tlast}, 32'd0);
    rst_n = 1'b1;
    cycle();

    // Default increments, continuous flow, wrap of both tones
    en = 1'b1; tready = 1'b1;
    cycle();
    check("t1_latency", {31'd0, tvalid}, 32'd1);
    obs_q.delete();
    repeat (140) cycle();
    check("t1_a1", {16'd0, obs_q[1][15:0]}, 32'd200);
    check("t1_b2", {16'd0, obs_q[2][31:16]}, 32'd6000);
    check("t2_a_pre", {16'd0, obs_q[128][15:0]}, 32'd25600);
    check("t2_a_wrap", {16'd0, obs_q[129][15:0]}, {16'd0, 16'hFFFF & 16'(-25672)});
    check("t2_b_wrap", {16'd0, obs_q[9][31:16]}, {16'd0, 16'hFFFF & 16'(-24472)});

    // Stop, then CLEAR with a simultaneous load in IDLE
    en = 1'b0;
    repeat (3) cycle();
    clear = 1'b1; inc_load = 1'b1; inc_a = 16'sd25536; inc_b = -16'sd24000;
    en = 1'b1; tready = 1'b0;
    obs_q.delete();
    cycle();
    en = 1'b0; tready = 1'b1; inc_load = 1'b1; inc_a = 16'sd200; inc_b = -16'sd3000;
    cycle();
    en = 1'b1; tready = 1'b0;
    cycle();
    tready = 1'b1;
    repeat (3) cycle();
    check("t2_clear_beat", obs_q[0], 32'd0);
    check("t2_a_exact_pi", {16'd0, obs_q[2][15:0]}, 32'd25736);
    check("t3_b_neg_wrap", {16'd0, obs_q[2][31:16]}, 32'd24472);
    check("t2_a_after_pi", {16'd0, obs_q[3][15:0]}, {16'd0, 16'hFFFF & 16'(-25536)});

    // Backpressure, invalid load, EN dropped during the stall
    tready = 1'b0;
    inc_load = 1'b1; inc_a = 16'sh7000; inc_b = 16'sd100;
    cycle();
    held = tdata;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_hold", tdata, held);
    end
    check("t5_err_sticky", {31'd0, inc_err}, 32'd1);
    tready = 1'b1;
    cycle();
    check("t5_drop_after_hs", {31'd0, tvalid}, 32'd0);
    en = 1'b1;
    repeat (6) cycle();

    // Reset mid-frame restarts from phase 0
    rst_n = 1'b0;
    cycle();
    check("t6_rst_tvalid", {31'd0, tvalid}, 32'd0);
    rst_n = 1'b1;
    cycle();
    check("t6_restart", tdata, 32'd0);
    repeat (5) cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      en       = ($urandom_range(0, 9) != 0);
      tready   = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 9) == 0);
      inc_load = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 3) == 0) begin
        inc_a = 16'($urandom);
        inc_b = 16'($urandom);
      end else begin
        inc_a = 16'(int'($urandom_range(0, TWO_PI)) - PI_P);
        inc_b = 16'(int'($urandom_range(0, TWO_PI)) - PI_P);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
